multicycle_control: RTL and testbench

Main control FSM for the multicycle MIPS core. It sequences every instruction through fetch, decode, execute, memory and writeback. It drives every select line of the datapath's 2-to-1 and 4-to-1 muxes (PC/ALUOut address, ALU operand A/B, writeback source, register destination, PC source) and every write-enable. It stalls on a single-bit memory-ready handshake and halts on unsupported opcodes.

---
 rtl/multicycle_control.sv | 150 +++++++++++++++
 tb/tb_multicycle_control.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS core: sequences fetch/decode/execute/memory/writeback
// and decodes every datapath select and write-enable from the state register.
module multicycle_control #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memToReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] pcSource,
    output logic       halted,
    output logic [3:0] stateOut
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_ILLEGAL   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:     r_state <= memReady ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE:      r_state <= S_R_EXEC;
                        OP_LW, OP_SW:  r_state <= S_MEM_ADDR;
                        OP_BEQ:        r_state <= S_BRANCH;
                        OP_J:          r_state <= S_JUMP;
                        OP_ADDI:       r_state <= S_ADDI_EXEC;
                        default:       r_state <= HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
                    endcase
                end
                S_MEM_ADDR:  r_state <= (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
                S_MEM_READ:  r_state <= memReady ? S_MEM_WB : S_MEM_READ;
                S_MEM_WB:    r_state <= S_FETCH;
                S_MEM_WRITE: r_state <= memReady ? S_FETCH : S_MEM_WRITE;
                S_R_EXEC:    r_state <= S_R_WB;
                S_R_WB:      r_state <= S_FETCH;
                S_BRANCH:    r_state <= S_FETCH;
                S_JUMP:      r_state <= S_FETCH;
                S_ADDI_EXEC: r_state <= S_ADDI_WB;
                S_ADDI_WB:   r_state <= S_FETCH;
                S_ILLEGAL:   r_state <= S_ILLEGAL;
                default:     r_state <= S_FETCH;
            endcase
        end
    end

    // Pure state decode; only FETCH looks at memReady so IR load and PC+4 share the completing edge.
    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memToReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        aluOp       = 2'b00;
        pcSource    = 2'b00;
        halted      = 1'b0;
        case (r_state)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                irWrite = memReady;
                pcWrite = memReady;
            end
            S_DECODE: aluSrcB = 2'b11;
            S_MEM_ADDR, S_ADDI_EXEC: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            S_MEM_READ: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            S_MEM_WB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            S_MEM_WRITE: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            S_R_EXEC: begin
                aluSrcA = 1'b1;
                aluOp   = 2'b10;
            end
            S_R_WB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = 2'b01;
                pcWriteCond = 1'b1;
                pcSource    = 2'b01;
            end
            S_JUMP: begin
                pcWrite  = 1'b1;
                pcSource = 2'b10;
            end
            S_ADDI_WB: regWrite = 1'b1;
            S_ILLEGAL: halted = 1'b1;
            default: ;
        endcase
    end

    assign stateOut = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-cycle vector table for normal instruction flows,
// plus hand sequences for illegal-opcode halt and asynchronous reset.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       memReady;

    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regDst, regWrite, aluSrcA, halted;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic [3:0] stateOut;

    logic       pcWrite_1, pcWriteCond_1, iorD_1, memRead_1, memWrite_1, irWrite_1;
    logic       memToReg_1, regDst_1, regWrite_1, aluSrcA_1, halted_1;
    logic [1:0] aluSrcB_1, aluOp_1, pcSource_1;
    logic [3:0] stateOut_1;

    always #5 clk = ~clk;

    multicycle_control #(.HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .memReady(memReady),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
        .memWrite(memWrite), .irWrite(irWrite), .memToReg(memToReg), .regDst(regDst),
        .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .pcSource(pcSource), .halted(halted), .stateOut(stateOut)
    );

    multicycle_control #(.HALT_ON_ILLEGAL(1'b0)) dut_nop (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .memReady(memReady),
        .pcWrite(pcWrite_1), .pcWriteCond(pcWriteCond_1), .iorD(iorD_1), .memRead(memRead_1),
        .memWrite(memWrite_1), .irWrite(irWrite_1), .memToReg(memToReg_1), .regDst(regDst_1),
        .regWrite(regWrite_1), .aluSrcA(aluSrcA_1), .aluSrcB(aluSrcB_1), .aluOp(aluOp_1),
        .pcSource(pcSource_1), .halted(halted_1), .stateOut(stateOut_1)
    );

    // {pcWrite,pcWriteCond,iorD,memRead,memWrite,irWrite,memToReg,regDst,regWrite,aluSrcA,aluSrcB,aluOp,pcSource,halted}
    logic [16:0] ctrl;
    assign ctrl = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg, regDst,
                   regWrite, aluSrcA, aluSrcB, aluOp, pcSource, halted};

    localparam logic [16:0] C_F1   = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_F0   = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_DEC  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] C_MA   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] C_MR   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_MWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] C_MW   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_REX  = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] C_RWB  = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] C_BR   = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] C_JMP  = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] C_AWB  = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [16:0] C_ILL  = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD = 6'b111111;

    typedef struct packed {
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [16:0] c;
    } vec_t;

    vec_t vecs[64];
    int   nv = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic [5:0] op, input logic mr, input logic [3:0] st, input logic [16:0] c);
        vecs[nv] = '{op: op, mr: mr, st: st, c: c};
        nv++;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin
        // lw, no stalls: 0,1,2,3,4
        add(OP_LW, 1, 0, C_F1);  add(OP_LW, 0, 1, C_DEC); add(OP_LW, 0, 2, C_MA);
        add(OP_LW, 1, 3, C_MR);  add(OP_LW, 0, 4, C_MWB);
        // sw with three stall cycles in MEM_WRITE
        add(OP_SW, 1, 0, C_F1);  add(OP_SW, 1, 1, C_DEC); add(OP_SW, 1, 2, C_MA);
        add(OP_SW, 0, 5, C_MW);  add(OP_SW, 0, 5, C_MW);  add(OP_SW, 0, 5, C_MW);
        add(OP_SW, 1, 5, C_MW);
        // R-type, beq, j, addi
        add(OP_R, 1, 0, C_F1);   add(OP_R, 0, 1, C_DEC);  add(OP_R, 1, 6, C_REX);  add(OP_R, 0, 7, C_RWB);
        add(OP_BEQ, 1, 0, C_F1); add(OP_BEQ, 1, 1, C_DEC); add(OP_BEQ, 0, 8, C_BR);
        add(OP_J, 1, 0, C_F1);   add(OP_J, 0, 1, C_DEC);  add(OP_J, 1, 9, C_JMP);
        add(OP_ADDI, 1, 0, C_F1); add(OP_ADDI, 1, 1, C_DEC); add(OP_ADDI, 0, 10, C_MA);
        add(OP_ADDI, 1, 11, C_AWB);
        // lw with two fetch stalls and one read stall
        add(OP_LW, 0, 0, C_F0);  add(OP_LW, 0, 0, C_F0);  add(OP_LW, 1, 0, C_F1);
        add(OP_LW, 1, 1, C_DEC); add(OP_LW, 1, 2, C_MA);  add(OP_LW, 0, 3, C_MR);
        add(OP_LW, 1, 3, C_MR);  add(OP_LW, 1, 4, C_MWB);
        add(OP_R, 0, 0, C_F0);

        // Reset state, no clock edge yet
        rst_n = 1'b0; opcode = OP_R; memReady = 1'b1;
        #1;
        check("reset_state", stateOut, 0);
        check("reset_ctrl_mr1", ctrl, C_F1);
        memReady = 1'b0;
        #1;
        check("reset_ctrl_mr0", ctrl, C_F0);

        for (int i = 0; i < nv; i++) begin
            @(negedge clk);
            rst_n = 1'b1; opcode = vecs[i].op; memReady = vecs[i].mr;
            #1;
            check($sformatf("vec%0d_state", i), stateOut, vecs[i].st);
            check($sformatf("vec%0d_ctrl", i), ctrl, vecs[i].c);
            check($sformatf("vec%0d_state_nop", i), stateOut_1, vecs[i].st);
            $display("vec %0d op=%b mr=%b state=%0d ctrl=%b", i, opcode, memReady, stateOut, ctrl);
        end

        // Illegal opcode: halt variant absorbs, NOP variant returns to FETCH
        @(negedge clk); opcode = OP_BAD; memReady = 1'b1; #1;
        check("ill_fetch", stateOut, 0);
        @(negedge clk); #1;
        check("ill_decode", stateOut, 1);
        check("ill_decode_nop", stateOut_1, 1);
        @(negedge clk); #1;
        check("ill_state", stateOut, 15);
        check("ill_ctrl", ctrl, C_ILL);
        check("ill_nop_state", stateOut_1, 0);
        $display("illegal: halt dut state=%0d halted=%b, nop dut state=%0d", stateOut, halted, stateOut_1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); memReady = 1'($urandom_range(0, 1)); opcode = 6'($urandom_range(0, 63)); #1;
            check($sformatf("ill_hold%0d_state", i), stateOut, 15);
            check($sformatf("ill_hold%0d_halted", i), halted, 1);
        end
        @(negedge clk); memReady = 1'b0; #1;
        rst_n = 1'b0; #1;
        check("ill_async_reset_state", stateOut, 0);
        check("ill_async_reset_ctrl", ctrl, C_F0);
        memReady = 1'b1; #1;
        check("reset_irwrite_follows_mr", ctrl, C_F1);
        $display("async reset from ILLEGAL: state=%0d halted=%b", stateOut, halted);

        // Reset during a MEM_READ stall aborts the lw
        @(negedge clk); rst_n = 1'b1; opcode = OP_LW; memReady = 1'b1; #1;
        check("abort_fetch", stateOut, 0);
        @(negedge clk); memReady = 1'b0; #1;
        check("abort_decode", stateOut, 1);
        @(negedge clk); #1;
        check("abort_maddr", stateOut, 2);
        @(negedge clk); #1;
        check("abort_mread", stateOut, 3);
        @(negedge clk); #1;
        check("abort_mread_stall", stateOut, 3);
        rst_n = 1'b0; #1;
        check("abort_async_state", stateOut, 0);
        check("abort_async_regwrite", regWrite, 0);
        check("abort_async_memwrite", memWrite, 0);
        $display("async reset in MEM_READ stall: state=%0d", stateOut);
        @(negedge clk); rst_n = 1'b1; opcode = OP_R; memReady = 1'b1; #1;
        check("post_fetch_state", stateOut, 0);
        check("post_fetch_rw", regWrite, 0);
        @(negedge clk); #1;
        check("post_decode_state", stateOut, 1);
        check("post_decode_rw", regWrite, 0);
        @(negedge clk); #1;
        check("post_rexec_state", stateOut, 6);
        check("post_rexec_rw", regWrite, 0);
        @(negedge clk); #1;
        check("post_rwb_state", stateOut, 7);
        check("post_rwb_rw", regWrite, 1);
        @(negedge clk); #1;
        check("post_done_state", stateOut, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
